// File: rtl/dds_channel_sched_pkg.sv
// Shared DDS constants and the phase accumulate rule used by the channel scheduler.
// PI2 is the CORDIC quarter-turn; a full turn is 4*PI2 in 18-bit angle units.
package dds_channel_sched_pkg;

   localparam int NCH_MAX = 16;
   localparam logic signed [18:0] PI2      = 19'sd51472;
   localparam logic signed [18:0] FOUR_PI2 = 19'sd205888;

   // Result always lands in [0, 4*PI2]; exactly 4*PI2 is kept, not folded to 0.
   function automatic logic [17:0] phase_acc(input logic [17:0] phase,
                                             input logic signed [15:0] inc);
      logic signed [18:0] sum;
      sum = $signed({1'b0, phase}) + $signed({{3{inc[15]}}, inc});
      if (sum > FOUR_PI2)
         sum = sum - FOUR_PI2;
      else if (sum < 19'sd0)
         sum = sum + FOUR_PI2;
      return sum[17:0];
   endfunction

endpackage

// File: rtl/dds_channel_sched_phase_bank.sv
// Per-channel phase storage plus live and frame-latched increments.
// One combinational read / registered write port addressed by ch.
module phase_bank
   import dds_channel_sched_pkg::*;
#(
   parameter int NCH  = 4,
   parameter int CH_W = $clog2(NCH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cfg_we,
   input  logic [CH_W-1:0]         cfg_ch,
   input  logic signed [15:0]      cfg_inc,
   input  logic                    load_frame,
   input  logic                    clr,
   input  logic [CH_W-1:0]         ch,
   input  logic                    wr_en,
   input  logic [17:0]             wr_phase,
   output logic [17:0]             rd_phase,
   output logic signed [15:0]      rd_inc
);

   logic [17:0]        phase     [NCH];
   logic signed [15:0] inc_live  [NCH];
   logic signed [15:0] inc_frame [NCH];

   assign rd_phase = phase[ch];
   assign rd_inc   = inc_frame[ch];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NCH; i++) begin
            phase[i]     <= '0;
            inc_live[i]  <= '0;
            inc_frame[i] <= '0;
         end
      end else begin
         if (cfg_we && (int'(cfg_ch) < NCH))
            inc_live[cfg_ch] <= cfg_inc;
         // Nonblocking copy: a write landing on the same edge is seen only by the next frame.
         if (load_frame)
            for (int i = 0; i < NCH; i++)
               inc_frame[i] <= inc_live[i];
         if (clr) begin
            for (int i = 0; i < NCH; i++)
               phase[i] <= '0;
         end else if (wr_en) begin
            phase[ch] <= wr_phase;
         end
      end
   end

endmodule

// File: rtl/dds_channel_sched.sv
// Round-robin scheduler sharing one cordicsine core across NCH DDS channels.
// Owns the frame FSM, the pending-channel mask and the CORDIC handshake.
module dds_channel_sched
   import dds_channel_sched_pkg::*;
#(
   parameter int NCH  = 4,
   parameter int CH_W = $clog2(NCH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tick,
   input  logic [NCH-1:0]          ch_enable,
   input  logic                    cfg_we,
   input  logic [CH_W-1:0]         cfg_ch,
   input  logic signed [15:0]      cfg_inc,
   input  logic                    phase_clr,
   output logic                    cs_update,
   output logic [17:0]             cs_angle,
   input  logic                    cs_ready,
   input  logic signed [15:0]      cs_result,
   output logic                    sample_valid,
   output logic [CH_W-1:0]         sample_ch,
   output logic signed [15:0]      sample_data,
   output logic                    busy,
   output logic                    overrun
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_SELECT    = 3'd1;
   localparam logic [2:0] S_ISSUE     = 3'd2;
   localparam logic [2:0] S_WAIT_LO   = 3'd3;
   localparam logic [2:0] S_WAIT_DONE = 3'd4;

   logic [2:0]         state;
   logic [NCH-1:0]     pending;
   logic [CH_W-1:0]    cur_ch;
   logic               clr_pend;
   logic [CH_W-1:0]    sel_ch;
   logic               sel_any;
   logic               load_frame;
   logic               clr_now;
   logic               wr_en;
   logic [17:0]        rd_phase;
   logic signed [15:0] rd_inc;
   logic [17:0]        next_phase;

   always_comb begin
      sel_ch  = '0;
      sel_any = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (pending[i]) begin
            sel_ch  = CH_W'(i);
            sel_any = 1'b1;
         end
      end
   end

   assign load_frame = (state == S_IDLE) && tick && (|ch_enable);
   assign wr_en      = (state == S_SELECT) && sel_any;
   assign next_phase = phase_acc(rd_phase, rd_inc);
   // A clear requested mid-frame is deferred to the SELECT->IDLE edge so the frame keeps old phases.
   assign clr_now    = ((state == S_IDLE) && phase_clr) ||
                       ((state == S_SELECT) && !sel_any && (clr_pend || phase_clr));

   phase_bank #(.NCH(NCH), .CH_W(CH_W)) u_phase_bank (
      .clk        (clk),
      .reset      (reset),
      .cfg_we     (cfg_we),
      .cfg_ch     (cfg_ch),
      .cfg_inc    (cfg_inc),
      .load_frame (load_frame),
      .clr        (clr_now),
      .ch         (sel_ch),
      .wr_en      (wr_en),
      .wr_phase   (next_phase),
      .rd_phase   (rd_phase),
      .rd_inc     (rd_inc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         pending      <= '0;
         cur_ch       <= '0;
         clr_pend     <= 1'b0;
         cs_update    <= 1'b0;
         cs_angle     <= '0;
         sample_valid <= 1'b0;
         sample_ch    <= '0;
         sample_data  <= '0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         cs_update    <= 1'b0;
         sample_valid <= 1'b0;

         if (clr_now) begin
            overrun  <= 1'b0;
            clr_pend <= 1'b0;
         end else if (phase_clr && (state != S_IDLE)) begin
            clr_pend <= 1'b1;
         end
         if (tick && (state != S_IDLE))
            overrun <= 1'b1;

         case (state)
            S_IDLE: begin
               if (load_frame) begin
                  pending <= ch_enable;
                  busy    <= 1'b1;
                  state   <= S_SELECT;
               end
            end
            S_SELECT: begin
               if (sel_any) begin
                  pending[sel_ch] <= 1'b0;
                  cur_ch          <= sel_ch;
                  cs_angle        <= next_phase;
                  cs_update       <= 1'b1;
                  state           <= S_ISSUE;
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            S_ISSUE:   state <= S_WAIT_LO;
            // The core still shows the previous ready for one cycle after an update.
            S_WAIT_LO: state <= S_WAIT_DONE;
            S_WAIT_DONE: begin
               if (cs_ready) begin
                  sample_data  <= cs_result;
                  sample_ch    <= cur_ch;
                  sample_valid <= 1'b1;
                  state        <= S_SELECT;
               end
            end
            default:   state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dds_channel_sched.sv
// Bench for dds_channel_sched: CORDIC stub, frame-level reference model, table rows,
// hand-written corner sequences and randomized frames.
module tb_dds_channel_sched;
   import dds_channel_sched_pkg::*;

   localparam int NCH = 4;
   localparam int CH_W = 2;
   localparam int FULL = 4 * int'(PI2);

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic tick = 1'b0;
   logic [NCH-1:0] ch_enable = '0;
   logic cfg_we = 1'b0;
   logic [CH_W-1:0] cfg_ch = '0;
   logic [15:0] cfg_inc = '0;
   logic phase_clr = 1'b0;
   logic cs_update;
   logic [17:0] cs_angle;
   logic cs_ready;
   logic [15:0] cs_result;
   logic sample_valid;
   logic [CH_W-1:0] sample_ch;
   logic [15:0] sample_data;
   logic busy;
   logic overrun;

   always #5 clk = ~clk;

   dds_channel_sched #(.NCH(NCH), .CH_W(CH_W)) dut (
      .clk(clk), .reset(reset), .tick(tick), .ch_enable(ch_enable),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .phase_clr(phase_clr),
      .cs_update(cs_update), .cs_angle(cs_angle), .cs_ready(cs_ready),
      .cs_result(cs_result), .sample_valid(sample_valid), .sample_ch(sample_ch),
      .sample_data(sample_data), .busy(busy), .overrun(overrun)
   );

   function automatic int f_res(int a);
      return ((a >> 2) ^ 'h5A5A) & 'hFFFF;
   endfunction

   // CORDIC stub: drops ready on update, raises it stub_lat+1 cycles later.
   int stub_lat = 0;
   int stub_cnt;
   logic [17:0] stub_angle;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         cs_ready <= 1'b1; stub_cnt <= 0; stub_angle <= '0;
      end else if (cs_update) begin
         cs_ready <= 1'b0; stub_cnt <= stub_lat; stub_angle <= cs_angle;
      end else if (!cs_ready) begin
         if (stub_cnt == 0) cs_ready <= 1'b1;
         else stub_cnt <= stub_cnt - 1;
      end
   end
   assign cs_result = 16'(f_res(int'(stub_angle)));

   typedef struct { int ch; int angle; } exp_t;
   exp_t exp_q[$];
   exp_t iss_q[$];
   int got_angle[$];
   int got_ch[$];
   int checks = 0, errors = 0, n_upd = 0, n_val = 0;
   int m_phase[NCH];
   int m_inc[NCH];

   task automatic check(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
      end
   endtask

   // Every clock advance goes through here so outputs are watched on each falling edge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (reset === 1'b1) begin
         if (cs_update) begin
            n_upd++;
            got_angle.push_back(int'(cs_angle));
            check("one_outstanding", int'(cs_ready), 1);
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL cs_update_unexpected angle=%0d expected=none", cs_angle);
            end else begin
               e = exp_q.pop_front();
               check("cs_angle", int'(cs_angle), e.angle);
               iss_q.push_back(e);
            end
         end
         if (sample_valid) begin
            n_val++;
            got_ch.push_back(int'(sample_ch));
            if (iss_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL sample_valid_unexpected ch=%0d expected=none", sample_ch);
            end else begin
               e = iss_q.pop_front();
               check("sample_ch", int'(sample_ch), e.ch);
               check("sample_data", int'(sample_data), f_res(e.angle));
            end
         end
      end
   endtask

   function automatic int acc(int p, int inc16);
      int s;
      s = p + ((inc16 >= 32768) ? inc16 - 65536 : inc16);
      if (s > FULL) s -= FULL;
      else if (s < 0) s += FULL;
      return s;
   endfunction

   task automatic model_frame(input logic [NCH-1:0] en);
      for (int c = 0; c < NCH; c++)
         if (en[c]) begin
            m_phase[c] = acc(m_phase[c], m_inc[c]);
            exp_q.push_back('{c, m_phase[c]});
         end
   endtask

   task automatic cfg_write(input int c, input int inc);
      cfg_we = 1'b1; cfg_ch = CH_W'(c); cfg_inc = 16'(inc);
      step();
      cfg_we = 1'b0;
      m_inc[c] = inc & 'hFFFF;
   endtask

   task automatic clr_idle();
      phase_clr = 1'b1;
      step();
      phase_clr = 1'b0;
      for (int c = 0; c < NCH; c++) m_phase[c] = 0;
   endtask

   task automatic wait_idle(input string nm, output int cnt);
      int guard;
      cnt = 0; guard = 0;
      while (busy === 1'b1 && guard < 3000) begin
         cnt++; guard++;
         step();
      end
      if (guard >= 3000) begin
         checks++; errors++;
         $display("FAIL %s_timeout got=busy expected=idle", nm);
      end
   endtask

   task automatic run_frame(input logic [NCH-1:0] en, input int lat, input bit race,
                            input int rch, input int rinc, input int exp_busy, input string nm);
      int cnt;
      stub_lat = lat;
      ch_enable = en;
      model_frame(en);
      tick = 1'b1;
      if (race) begin cfg_we = 1'b1; cfg_ch = CH_W'(rch); cfg_inc = 16'(rinc); end
      step();
      tick = 1'b0; cfg_we = 1'b0;
      if (race) m_inc[rch] = rinc & 'hFFFF;
      wait_idle(nm, cnt);
      if (exp_busy >= 0) check({nm, "_busy"}, cnt, exp_busy);
      step(); step();
      check({nm, "_drain"}, exp_q.size() + iss_q.size(), 0);
      exp_q.delete(); iss_q.delete();
   endtask

   typedef struct {
      logic [3:0] en;
      logic [15:0] inc0, inc1, inc2, inc3;
      int lat;
      int exp_busy;
   } vec_t;
   vec_t tbl[6];

   initial begin
      int cnt, n0, k, lat, nw;
      logic [3:0] en;
      for (int c = 0; c < NCH; c++) begin m_phase[c] = 0; m_inc[c] = 0; end

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_cs_update", int'(cs_update), 0);
      check("rst_cs_angle", int'(cs_angle), 0);
      check("rst_sample_valid", int'(sample_valid), 0);
      check("rst_sample_ch", int'(sample_ch), 0);
      check("rst_sample_data", int'(sample_data), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_overrun", int'(overrun), 0);
      reset = 1'b1;
      step();

      // Single channel, three ticks
      cfg_write(0, 'h100);
      got_angle.delete(); got_ch.delete(); n0 = n_val;
      for (int i = 0; i < 3; i++) run_frame(4'b0001, 0, 0, 0, 0, 5, "single");
      check("single_n_upd", got_angle.size(), 3);
      if (got_angle.size() == 3) begin
         check("single_a0", got_angle[0], 'h100);
         check("single_a1", got_angle[1], 'h200);
         check("single_a2", got_angle[2], 'h300);
      end
      check("single_n_valid", n_val - n0, 3);
      foreach (got_ch[i]) check("single_ch", got_ch[i], 0);

      // Round robin
      clr_idle();
      cfg_write(0, 1); cfg_write(1, 2); cfg_write(2, 0); cfg_write(3, 8);
      got_ch.delete();
      run_frame(4'b1011, 0, 0, 0, 0, 13, "rr");
      check("rr_n", got_ch.size(), 3);
      if (got_ch.size() == 3) begin
         check("rr_ch0", got_ch[0], 0);
         check("rr_ch1", got_ch[1], 1);
         check("rr_ch2", got_ch[2], 3);
      end

      // Negative wrap from 0
      clr_idle();
      cfg_write(0, 'hFFFF);
      got_angle.delete();
      run_frame(4'b0001, 0, 0, 0, 0, 5, "wrapneg");
      if (got_angle.size() > 0) check("wrapneg_angle", got_angle[$], FULL - 1);

      // Positive wrap: 6*0x7FFF then one more step past a full turn
      clr_idle();
      cfg_write(0, 'h7FFF);
      got_angle.delete();
      for (int i = 0; i < 7; i++) run_frame(4'b0001, 0, 0, 0, 0, 5, "wrappos");
      check("wrappos_n", got_angle.size(), 7);
      if (got_angle.size() == 7) begin
         check("wrappos_a5", got_angle[5], 196602);
         check("wrappos_a6", got_angle[6], 229369 - FULL);
      end

      // Exactly 4*PI2 is kept, one more folds to 1
      clr_idle();
      for (int i = 0; i < 6; i++) run_frame(4'b0001, 0, 0, 0, 0, 5, "edge_pre");
      cfg_write(0, FULL - 196602);
      got_angle.delete();
      run_frame(4'b0001, 0, 0, 0, 0, 5, "edge_eq");
      cfg_write(0, 1);
      run_frame(4'b0001, 0, 0, 0, 0, 5, "edge_over");
      if (got_angle.size() == 2) begin
         check("edge_eq_angle", got_angle[0], FULL);
         check("edge_over_angle", got_angle[1], 1);
      end else check("edge_n", got_angle.size(), 2);

      // Overrun: second tick two cycles after the first
      clr_idle();
      cfg_write(0, 'h10);
      stub_lat = 0; ch_enable = 4'b0001;
      n0 = n_upd;
      model_frame(4'b0001);
      tick = 1'b1; step(); tick = 1'b0; step();
      tick = 1'b1; step(); tick = 1'b0;
      wait_idle("ovr", cnt);
      step(); step();
      check("ovr_flag", int'(overrun), 1);
      check("ovr_n_upd", n_upd - n0, 1);
      exp_q.delete(); iss_q.delete();
      clr_idle();
      check("ovr_cleared", int'(overrun), 0);
      got_angle.delete();
      run_frame(4'b0001, 0, 0, 0, 0, 5, "ovr_after");
      if (got_angle.size() > 0) check("ovr_after_angle", got_angle[$], 'h10);

      // phase_clr during a frame: frame keeps old phase, next frame restarts from 0
      stub_lat = 2;
      model_frame(4'b0001);
      tick = 1'b1; step(); tick = 1'b0; step();
      phase_clr = 1'b1; step(); phase_clr = 1'b0;
      wait_idle("midclr", cnt);
      step(); step();
      check("midclr_drain", exp_q.size() + iss_q.size(), 0);
      for (int c = 0; c < NCH; c++) m_phase[c] = 0;
      got_angle.delete();
      run_frame(4'b0001, 0, 0, 0, 0, 5, "midclr_next");
      if (got_angle.size() > 0) check("midclr_next_angle", got_angle[$], 'h10);

      // Config write racing the tick
      clr_idle();
      cfg_write(0, 'h20);
      got_angle.delete();
      run_frame(4'b0001, 0, 1, 0, 'h40, 5, "race1");
      run_frame(4'b0001, 0, 0, 0, 0, 5, "race2");
      if (got_angle.size() == 2) begin
         check("race_old_inc", got_angle[0], 'h20);
         check("race_new_inc", got_angle[1], 'h60);
      end else check("race_n", got_angle.size(), 2);

      // Reset while waiting on the core
      stub_lat = 10; ch_enable = 4'b0001;
      model_frame(4'b0001);
      tick = 1'b1; step(); tick = 1'b0;
      step(); step(); step();
      #2 reset = 1'b0;
      #1;
      check("mrst_busy", int'(busy), 0);
      check("mrst_cs_update", int'(cs_update), 0);
      check("mrst_cs_angle", int'(cs_angle), 0);
      check("mrst_valid", int'(sample_valid), 0);
      check("mrst_overrun", int'(overrun), 0);
      exp_q.delete(); iss_q.delete();
      for (int c = 0; c < NCH; c++) begin m_phase[c] = 0; m_inc[c] = 0; end
      step(); step();
      reset = 1'b1;
      n0 = n_val;
      repeat (20) step();
      check("mrst_no_valid", n_val - n0, 0);
      cfg_write(0, 'h55);
      got_angle.delete();
      run_frame(4'b0001, 1, 0, 0, 0, 6, "mrst_clean");
      if (got_angle.size() > 0) check("mrst_clean_angle", got_angle[$], 'h55);

      // Table rows
      tbl[0] = '{4'b0001, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 0, 5};
      tbl[1] = '{4'b1011, 16'h0001, 16'h0002, 16'h0000, 16'h0008, 0, 13};
      tbl[2] = '{4'b1111, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF, 2, 25};
      tbl[3] = '{4'b0000, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 0, 0};
      tbl[4] = '{4'b1000, 16'h0003, 16'h0004, 16'h0005, 16'h8001, 5, 10};
      tbl[5] = '{4'b0110, 16'hABCD, 16'h4000, 16'hC000, 16'h0001, 1, 11};
      for (int r = 0; r < 6; r++) begin
         cfg_write(0, int'(tbl[r].inc0)); cfg_write(1, int'(tbl[r].inc1));
         cfg_write(2, int'(tbl[r].inc2)); cfg_write(3, int'(tbl[r].inc3));
         run_frame(tbl[r].en, tbl[r].lat, 0, 0, 0, tbl[r].exp_busy, $sformatf("tbl%0d", r));
      end

      // Randomized frames against the model
      for (int it = 0; it < 40; it++) begin
         nw = $urandom_range(0, 2);
         for (int w = 0; w < nw; w++) begin
            case ($urandom_range(0, 3))
               0: cfg_write($urandom_range(0, NCH - 1), 'h7FFF);
               1: cfg_write($urandom_range(0, NCH - 1), 'h8000);
               default: cfg_write($urandom_range(0, NCH - 1), int'($urandom_range(0, 65535)));
            endcase
         end
         if ($urandom_range(0, 7) == 0) clr_idle();
         en = 4'($urandom_range(0, 15));
         lat = $urandom_range(0, 3);
         k = 0;
         for (int c = 0; c < NCH; c++) k += int'(en[c]);
         run_frame(en, lat, 0, 0, 0, (k == 0) ? 0 : k * (4 + lat) + 1, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
